// File: rtl/binary_region_stats.sv
// Per-frame white-pixel area and bounding box of a binary video stream.
// Results are published once at the end of each frame, together with a one-cycle stats_valid strobe.
module binary_region_stats #(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int XW       = (($clog2(IMG_W) > $clog2(IMG_H)) ? $clog2(IMG_W) : $clog2(IMG_H)) + 1,
   parameter int AW       = 20,
   parameter int MIN_AREA = 64
) (
   input  logic          pixelclk,
   input  logic          rst_n,
   input  logic          per_frame_vsync,
   input  logic          per_frame_href,
   input  logic          per_frame_clken,
   input  logic          per_img_Bit,
   output logic [AW-1:0] area_cnt,
   output logic [XW-1:0] x_min,
   output logic [XW-1:0] x_max,
   output logic [XW-1:0] y_min,
   output logic [XW-1:0] y_max,
   output logic          obj_found,
   output logic          stats_valid
);

   localparam logic [XW-1:0] C_MAX      = '1;
   localparam logic [AW-1:0] A_MAX      = '1;
   localparam logic [AW:0]   MIN_AREA_W = (AW+1)'(MIN_AREA);

   logic          vs_d, hs_d, vs_low_seen, frame_armed;
   logic          vs_rise, vs_fall, hs_fall, pix_ok, hit;
   logic [XW-1:0] x, y;
   logic [AW-1:0] acc_area;
   logic [XW-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;

   // A vsync that is already high when reset is released belongs to a partial
   // frame, so a rising edge only counts once vsync has been seen low.
   always_comb begin
      vs_rise = per_frame_vsync & ~vs_d & vs_low_seen;
      vs_fall = ~per_frame_vsync & vs_d;
      hs_fall = ~per_frame_href & hs_d;
      pix_ok  = per_frame_vsync & per_frame_href & per_frame_clken;
      hit     = pix_ok & per_img_Bit;
   end

   always_ff @(posedge pixelclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d        <= 1'b0;
         hs_d        <= 1'b0;
         vs_low_seen <= 1'b0;
         x           <= '0;
         y           <= '0;
      end else begin
         vs_d        <= per_frame_vsync;
         hs_d        <= per_frame_href;
         vs_low_seen <= vs_low_seen | ~per_frame_vsync;
         if (vs_rise || hs_fall)
            x <= '0;
         else if (pix_ok && x != C_MAX)
            x <= x + 1'b1;
         if (vs_rise)
            y <= '0;
         else if (hs_fall && per_frame_vsync && y != C_MAX)
            y <= y + 1'b1;
      end
   end

   always_ff @(posedge pixelclk or negedge rst_n) begin
      if (!rst_n) begin
         acc_area    <= '0;
         acc_xmin    <= '0;
         acc_xmax    <= '0;
         acc_ymin    <= '0;
         acc_ymax    <= '0;
         frame_armed <= 1'b0;
      end else if (vs_rise) begin
         acc_area    <= '0;
         acc_xmin    <= C_MAX;
         acc_xmax    <= '0;
         acc_ymin    <= C_MAX;
         acc_ymax    <= '0;
         frame_armed <= 1'b1;
      end else begin
         if (hit) begin
            if (acc_area != A_MAX) acc_area <= acc_area + 1'b1;
            if (x < acc_xmin) acc_xmin <= x;
            if (x > acc_xmax) acc_xmax <= x;
            if (y < acc_ymin) acc_ymin <= y;
            if (y > acc_ymax) acc_ymax <= y;
         end
         if (vs_fall) frame_armed <= 1'b0;
      end
   end

   always_ff @(posedge pixelclk or negedge rst_n) begin
      if (!rst_n) begin
         area_cnt    <= '0;
         x_min       <= '0;
         x_max       <= '0;
         y_min       <= '0;
         y_max       <= '0;
         obj_found   <= 1'b0;
         stats_valid <= 1'b0;
      end else if (vs_fall && frame_armed) begin
         area_cnt    <= acc_area;
         obj_found   <= ({1'b0, acc_area} >= MIN_AREA_W);
         stats_valid <= 1'b1;
         // An empty frame reports a zero box rather than the inverted sentinels.
         if (acc_area == '0) begin
            x_min <= '0;
            x_max <= '0;
            y_min <= '0;
            y_max <= '0;
         end else begin
            x_min <= acc_xmin;
            x_max <= acc_xmax;
            y_min <= acc_ymin;
            y_max <= acc_ymax;
         end
      end else begin
         stats_valid <= 1'b0;
      end
   end

endmodule
